// File: rtl/cpu_test_monitor.sv
// cpu_test_monitor: snoops CPU stores for tohost pass/fail, a run timeout and console bytes.
// Define MON_CONSOLE_EN to build the console FIFO; otherwise the console outputs are tied to 0.
module cpu_test_monitor #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_1000,
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR = 32'h0000_1004,
  parameter int TIMEOUT = 100000,
  parameter int CNT_W = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [1:0]        state,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [DATA_W-1:0] fail_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              con_valid,
  output logic [7:0]        con_data,
  input  logic              con_ready,
  output logic              con_overflow
);
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} st_t;
  st_t st;
  logic tohost;
  assign tohost = wr_en && mem_addr == TOHOST_ADDR;
  assign state = st;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      done <= 1'b0;
      pass <= 1'b0;
      timed_out <= 1'b0;
      fail_code <= '0;
      cycle_count <= '0;
    end else if (start) begin
      st <= RUN;
      done <= 1'b0;
      pass <= 1'b0;
      timed_out <= 1'b0;
      fail_code <= '0;
      cycle_count <= '0;
    end else if (st == RUN) begin
      if (tohost && w_data == DATA_W'(1)) begin
        st <= PASS;
        done <= 1'b1;
        pass <= 1'b1;
      end else if (tohost && w_data != '0) begin
        st <= FAIL;
        done <= 1'b1;
        fail_code <= w_data >> 1;
      end else if (cycle_count == CNT_W'(TIMEOUT - 1)) begin
        st <= FAIL;
        done <= 1'b1;
        timed_out <= 1'b1;
      end else if (~&cycle_count)
        cycle_count <= cycle_count + 1'b1;
    end
`ifdef MON_CONSOLE_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;
  logic push, pop, full, acc;
  assign push = wr_en && mem_addr == CONSOLE_ADDR;
  assign pop = con_valid && con_ready;
  assign full = (wptr ^ rptr) == (AW+1)'(FIFO_DEPTH);
  assign acc = push && (!full || pop);
  assign wptr_n = wptr + (AW+1)'(acc);
  assign rptr_n = rptr + (AW+1)'(pop);
  always_ff @(posedge clk)
    if (acc) mem[wptr[AW-1:0]] <= w_data[7:0];
  // con_data is registered: the next head is the fresh byte when it lands in the head slot
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      con_valid <= 1'b0;
      con_data <= '0;
      con_overflow <= 1'b0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      con_valid <= wptr_n != rptr_n;
      con_data <= (acc && rptr_n[AW-1:0] == wptr[AW-1:0]) ? w_data[7:0] : mem[rptr_n[AW-1:0]];
      con_overflow <= (con_overflow && !start) || (push && full && !pop);
    end
`else
  logic unused_con;
  assign unused_con = ^{con_ready, CONSOLE_ADDR, FIFO_DEPTH};
  assign con_valid = 1'b0;
  assign con_data = '0;
  assign con_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_test_monitor.sv
// tb_cpu_test_monitor: directed stimulus with a scoreboard of run results and console bytes.
module tb_cpu_test_monitor;
  logic clk = 0, rst = 0, start = 0, wr_en = 0, con_ready = 0;
  logic [31:0] mem_addr = 0, w_data = 0;
  logic [1:0] state;
  logic done, pass, timed_out, con_valid, con_overflow;
  logic [31:0] fail_code, cycle_count;
  logic [7:0] con_data;
  int checks = 0, fails = 0;
  logic prev_done = 0;
  typedef struct packed {logic [1:0] st; logic p; logic t; logic [31:0] fc; logic [31:0] cc;} res_t;
  res_t exp_q[$];
  logic [7:0] byte_q[$];

  cpu_test_monitor #(.TIMEOUT(50), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .mem_addr(mem_addr), .w_data(w_data),
    .state(state), .done(done), .pass(pass), .timed_out(timed_out), .fail_code(fail_code),
    .cycle_count(cycle_count), .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
    .con_overflow(con_overflow));

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d);
    wr_en = 1;
    mem_addr = a;
    w_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic expect_res(logic [1:0] s, logic p, logic t, logic [31:0] fc, logic [31:0] cc);
    res_t r;
    r.st = s; r.p = p; r.t = t; r.fc = fc; r.cc = cc;
    exp_q.push_back(r);
  endtask

  task automatic wait_done(int lim);
    for (int i = 0; i < lim && !done; i++) tick();
    chk("done_within_budget", {31'd0, done}, 1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_done: state %0d", state);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("res_state", {30'd0, state}, {30'd0, e.st});
          chk("res_pass", {31'd0, pass}, {31'd0, e.p});
          chk("res_timed_out", {31'd0, timed_out}, {31'd0, e.t});
          chk("res_fail_code", fail_code, e.fc);
          chk("res_cycle_count", cycle_count, e.cc);
        end
      end
      if (con_valid && con_ready) begin
        if (byte_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_byte: got %0h", con_data);
        end else chk("con_byte", {24'd0, con_data}, {24'd0, byte_q.pop_front()});
      end
    end
    prev_done = done;
  end

  initial begin
    tick(); tick();
    chk("rst_state", {30'd0, state}, 0);
    chk("rst_flags", {27'd0, done, pass, timed_out, con_valid, con_overflow}, 0);
    chk("rst_fail_code", fail_code, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_con_data", {24'd0, con_data}, 0);
    rst = 1;
    tick();
    // pass at RUN cycle 10
    do_start();
    chk("run_state", {30'd0, state}, 1);
    repeat (10) tick();
    expect_res(2, 1, 0, 0, 10);
    store(32'h1000, 1);
    repeat (3) tick();
    chk("pass_count_held", cycle_count, 10);
    // fail code 0xB >> 1, later pass store ignored
    do_start();
    store(32'h1000, 0);
    chk("zero_store_ignored", {30'd0, state}, 1);
    expect_res(3, 0, 0, 5, 1);
    store(32'h1000, 32'hB);
    store(32'h1000, 1);
    tick();
    chk("fail_sticky_state", {30'd0, state}, 3);
    chk("fail_sticky_pass", {31'd0, pass}, 0);
    // timeout
    do_start();
    chk("restart_clears_code", fail_code, 0);
    expect_res(3, 0, 1, 0, 49);
    wait_done(60);
    tick();
    // pass on the timeout edge
    do_start();
    repeat (49) tick();
    expect_res(2, 1, 0, 0, 49);
    store(32'h1000, 1);
    tick();
`ifdef MON_CONSOLE_EN
    con_ready = 0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) byte_q.push_back(8'(8'h41 + i));
      store(32'h1004, 32'h41 + i);
    end
    chk("ovf_set", {31'd0, con_overflow}, 1);
    chk("full_valid", {31'd0, con_valid}, 1);
    chk("full_head", {24'd0, con_data}, 32'h41);
    con_ready = 1;
    repeat (18) tick();
    chk("drained_valid", {31'd0, con_valid}, 0);
    chk("drained_queue", byte_q.size(), 0);
    con_ready = 0;
    do_start();
    chk("start_clears_ovf", {31'd0, con_overflow}, 0);
    expect_res(2, 1, 0, 0, 0);
    store(32'h1000, 1);
    for (int i = 0; i < 16; i++) begin
      byte_q.push_back(8'(8'h61 + i));
      store(32'h1004, 32'h61 + i);
    end
    con_ready = 1;
    byte_q.push_back(8'h5A);
    store(32'h1004, 32'h5A);
    chk("pushpop_no_ovf", {31'd0, con_overflow}, 0);
    repeat (20) tick();
    chk("pushpop_drained", byte_q.size(), 0);
    chk("pushpop_valid", {31'd0, con_valid}, 0);
    con_ready = 0;
`else
    store(32'h1004, 32'h41);
    tick();
    chk("con_off_valid", {31'd0, con_valid}, 0);
    chk("con_off_ovf", {31'd0, con_overflow}, 0);
`endif
    // async reset mid-run with queued bytes
    do_start();
    store(32'h1004, 32'h31);
    store(32'h1004, 32'h32);
    store(32'h1004, 32'h33);
    #2 rst = 0;
    #1;
    chk("arst_state", {30'd0, state}, 0);
    chk("arst_flags", {27'd0, done, pass, timed_out, con_valid, con_overflow}, 0);
    chk("arst_count", cycle_count, 0);
    chk("arst_con_data", {24'd0, con_data}, 0);
    tick();
    rst = 1;
    tick();
    do_start();
    repeat (3) tick();
    expect_res(2, 1, 0, 0, 3);
    store(32'h1000, 1);
    repeat (3) tick();
    chk("post_rst_con_valid", {31'd0, con_valid}, 0);
    chk("res_queue_empty", exp_q.size(), 0);
    chk("byte_queue_empty", byte_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/cpu_test_monitor.md
# cpu_test_monitor

Synthesisable, parametrised bus monitor that sits beside `cpu` on the `rw_ram` data port and turns a free-running CPU simulation into a self-checking run. It snoops CPU stores and decodes a write to a `TOHOST_ADDR` mailbox as pass or fail. It enforces a cycle-count timeout. It also buffers bytes stored to a `CONSOLE_ADDR` port in a FIFO that the bench or a UART drains over a ready/valid handshake.

## Interface
- `ADDR_W`, 32: snooped address width.
- `DATA_W`, 32: snooped write-data width (≥ 8).
- `TOHOST_ADDR`, 32'h0000_1000: pass/fail mailbox address.
- `CONSOLE_ADDR`, 32'h0000_1004: console byte port address.
- `TIMEOUT`, 100000: cycles in RUN before TIMEOUT (≥ 1).
- `CNT_W`, 32: cycle counter width.
- `FIFO_DEPTH`, 16: console FIFO entries (power of 2, ≥ 2).

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-low (0 = reset).
- `start` in 1: one-cycle pulse that begins a run.
- `wr_en` in 1: CPU store strobe.
- `mem_addr` in `ADDR_W`: CPU store address.
- `w_data` in `DATA_W`: CPU store data.
- `state` out 2: 0 IDLE, 1 RUN, 2 PASS, 3 FAIL_OR_TIMEOUT (see `timed_out`).
- `done` out 1: high in PASS or FAIL_OR_TIMEOUT.
- `pass` out 1: high only in PASS.
- `timed_out` out 1: high only when the run ended by timeout.
- `fail_code` out `DATA_W`: `w_data >> 1` of the failing mailbox write; 0 otherwise.
- `cycle_count` out `CNT_W`: cycles spent in RUN.
- `con_valid` out 1: FIFO head valid.
- `con_data` out 8: FIFO head byte.
- `con_ready` in 1: consumer accepts the head.
- `con_overflow` out 1: sticky flag; a console byte was dropped.

## Operation
- Reset: state IDLE; `done`, `pass`, `timed_out`, `fail_code`, `cycle_count`, `con_valid`, `con_data`, `con_overflow` all 0; FIFO empty.
- IDLE → RUN on `start`. On entry, `cycle_count` clears.
- RUN, store with `wr_en`=1 and `mem_addr`==`TOHOST_ADDR`:
  - `w_data`==1 → PASS.
  - `w_data`==0 → ignored.
  - any other value → FAIL_OR_TIMEOUT, `fail_code`=`w_data>>1`.
- RUN, `cycle_count` reaches `TIMEOUT-1` with no mailbox write that cycle → FAIL_OR_TIMEOUT, `timed_out`=1, `fail_code`=0.
- Same-cycle mailbox write and timeout: the mailbox write wins.
- `cycle_count` increments once per RUN cycle, saturates at all-ones, and holds in terminal states.
- PASS and FAIL_OR_TIMEOUT are sticky. Mailbox writes are ignored in these states. `start` → RUN, clearing `cycle_count`, `fail_code`, `timed_out` and `con_overflow`. FIFO contents are kept.
- `start` in RUN: the run restarts, with the same clears.
- Console: a store to `CONSOLE_ADDR` in any state pushes `w_data[7:0]`.
- Full FIFO with no pop that cycle: the byte is dropped and `con_overflow` sets.
- Full FIFO with a pop the same cycle: the push is accepted.
- Pop on `con_valid && con_ready`. `con_ready` while empty has no effect.
- Pointers wrap modulo `FIFO_DEPTH` and carry one extra bit for full/empty.
- Async reset mid-run: everything returns to reset values immediately and the FIFO contents are lost.

## Timing
- Every output is registered.
- Mailbox store sampled at edge N → `state`, `done`, `pass` and `fail_code` update after edge N.
- `cycle_count` counts RUN cycles starting at 0 after the `start` edge. Timeout fires at the edge where the count would reach `TIMEOUT`, so `cycle_count`==`TIMEOUT-1` is shown in FAIL_OR_TIMEOUT.
- Console push at edge N → `con_valid` high after edge N. There is no same-cycle bypass.
- `con_data` is stable while `con_valid && !con_ready`.
- Sustained throughput is one push and one pop per cycle.

## Configuration
- `MON_CONSOLE_EN` defined: the console FIFO and its handshake are built as described.
- `MON_CONSOLE_EN` undefined:
  - No FIFO is instantiated and console stores are ignored.
  - `con_valid`, `con_data` and `con_overflow` are tied to 0; `con_ready` is unused.
  - Mailbox and timeout behaviour is identical to the defined build.

## Test plan
- Reset release, `start`, then a store of 1 to 0x1000 at RUN cycle 10 → PASS, `done`=1, `pass`=1, `cycle_count`=10 held.
- `start`, then a store of 0x0000_000B to 0x1000 → FAIL_OR_TIMEOUT, `fail_code`=5, `timed_out`=0. A second store of 1 is ignored.
- `TIMEOUT`=50, `start`, no stores → FAIL_OR_TIMEOUT after 50 RUN cycles, `timed_out`=1, `cycle_count`=49. Variant: a store of 1 on that exact edge → PASS.
- `con_ready`=0, 17 stores of 0x41.. to 0x1004 with `FIFO_DEPTH`=16 → 16 bytes held and `con_overflow`=1. Then `con_ready`=1 → 0x41..0x50 drain in order, one per cycle, then `con_valid`=0.
- FIFO full with simultaneous push 0x5A and pop → no overflow, 0x5A delivered last.
- `rst` pulled low mid-RUN with 3 bytes queued → all outputs 0 asynchronously, FIFO empty, state IDLE. `start` then runs normally.
